// File: rtl/key_debounce_if.sv
// key_debounce_if: key pins in, debounced levels and edge pulses out.
//   key_in      raw active-low key pins (driven by master)
//   key_level   debounced level, same polarity as key_in
//   key_press   one-cycle pulse on an accepted 1->0 transition
//   key_release one-cycle pulse on an accepted 0->1 transition
//   key_long    one-cycle long-press pulse (only with KEY_LONG_PRESS_EN)
// master = board/bench side, slave = debouncer side.
interface key_debounce_if #(
    parameter int KEY_W = 2
);
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_level;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
`ifdef KEY_LONG_PRESS_EN
    logic [KEY_W-1:0] key_long;
    modport master (output key_in, input key_level, key_press, key_release, key_long);
    modport slave  (input key_in, output key_level, key_press, key_release, key_long);
`else
    modport master (output key_in, input key_level, key_press, key_release);
    modport slave  (input key_in, output key_level, key_press, key_release);
`endif
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronise and counter-debounce active-low keys, emitting levels and press/release pulses.
//   sys_clk  system clock
//   rst      asynchronous, active-low reset
//   kif      key_debounce_if.slave (key_in in; key_level, key_press, key_release[, key_long] out)
// Optional macro KEY_LONG_PRESS_EN adds LONG_CNT, a per-key hold counter and the key_long pulse.
module key_debounce #(
    parameter int          KEY_W    = 2,
    parameter logic [19:0] DEB_CNT  = 20'd1000000
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter logic [25:0] LONG_CNT = 26'd50000000
`endif
) (
    input logic          sys_clk,
    input logic          rst,
    key_debounce_if.slave kif
);
    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;
    logic [KEY_W-1:0] sync_a;
    logic [KEY_W-1:0] sync_b;
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= kif.key_in;
            sync_b <= sync_a;
        end
    end
    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        state_t      state;
        state_t      state_nxt;
        logic [19:0] cnt;
        logic [19:0] cnt_nxt;
        logic        lvl;
        logic        lvl_nxt;
        logic        prs;
        logic        prs_nxt;
        logic        rel;
        logic        rel_nxt;
        logic        last;
        assign last = cnt == DEB_CNT - 20'd1;
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            lvl_nxt   = lvl;
            prs_nxt   = 1'b0;
            rel_nxt   = 1'b0;
            case (state)
                IDLE: if (!sync_b[i]) begin
                    state_nxt = PRESS_DEB;
                    cnt_nxt   = 20'd1;
                end
                PRESS_DEB: if (sync_b[i]) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    lvl_nxt   = 1'b0;
                    prs_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 20'd1;
                end
                HELD: if (sync_b[i]) begin
                    state_nxt = RELEASE_DEB;
                    cnt_nxt   = 20'd1;
                end
                RELEASE_DEB: if (!sync_b[i]) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    lvl_nxt   = 1'b1;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 20'd1;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
        always_ff @(posedge sys_clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
                lvl   <= 1'b1;
                prs   <= 1'b0;
                rel   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                lvl   <= lvl_nxt;
                prs   <= prs_nxt;
                rel   <= rel_nxt;
            end
        end
        assign kif.key_level[i]   = lvl;
        assign kif.key_press[i]   = prs;
        assign kif.key_release[i] = rel;
`ifdef KEY_LONG_PRESS_EN
        logic [25:0] hold;
        logic [25:0] hold_nxt;
        logic        lng;
        logic        lng_nxt;
        logic        down;
        assign down = state == HELD || state == RELEASE_DEB;
        // The counter parks at LONG_CNT after the pulse, so each press yields at most one key_long;
        // a release bounce back to HELD keeps the running count.
        always_comb begin
            hold_nxt = hold;
            lng_nxt  = 1'b0;
            if (down) begin
                lng_nxt  = hold == LONG_CNT - 26'd1;
                hold_nxt = state_nxt == IDLE ? '0 : (hold == LONG_CNT ? hold : hold + 26'd1);
            end else if (state_nxt == HELD) begin
                hold_nxt = '0;
            end
        end
        always_ff @(posedge sys_clk or negedge rst) begin
            if (!rst) begin
                hold <= '0;
                lng  <= 1'b0;
            end else begin
                hold <= hold_nxt;
                lng  <= lng_nxt;
            end
        end
        assign kif.key_long[i] = lng;
`endif
    end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Input conditioning stage between the board push-buttons and the LED key-control logic. It synchronises each raw, active-low key input to sys_clk and filters contact bounce with a per-key counter state machine. It outputs clean key levels plus single-cycle press/release pulses. The downstream LED controller consumes key_level in place of the raw pins.

Parameters:
KEY_W, 2, number of independent keys.
DEB_CNT, 20'd1000000, stable cycles required to accept a level change (20 ms at 50 MHz); simulation value 20.
LONG_CNT, 26'd50000000, cycles held low before a long-press pulse (1 s at 50 MHz); simulation value 100; used only with KEY_LONG_PRESS_EN.

Ports:
sys_clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous, active-low reset.
key_in  input  KEY_W  raw key pins; 1 = released, 0 = pressed; asynchronous to sys_clk.
key_level  output  KEY_W  debounced key level; same polarity as key_in.
key_press  output  KEY_W  one-cycle pulse on an accepted 1->0 transition.
key_release  output  KEY_W  one-cycle pulse on an accepted 0->1 transition.
key_long  output  KEY_W  one-cycle long-press pulse; present only with KEY_LONG_PRESS_EN.

Behaviour:
- Reset is asynchronous and active-low. Clock is sys_clk.
- Reset values: key_level = all 1s, key_press = 0, key_release = 0, key_long = 0. Synchroniser flops = all 1s. Counters = 0. FSMs = IDLE.
- Reset asserted mid-debounce aborts it immediately with no pulse. After release, a key held low must be re-qualified from zero.
- Synchroniser: 2 flops per key, giving sync[i].
- Each key has an independent FSM with states IDLE (stable high), PRESS_DEB, HELD (stable low), RELEASE_DEB:
  - IDLE: sync=0 -> PRESS_DEB, cnt=1.
  - PRESS_DEB: sync=1 -> IDLE, cnt=0 (bounce rejected, no pulse). sync=0 and cnt<DEB_CNT-1 -> cnt+1. sync=0 and cnt==DEB_CNT-1 -> HELD, cnt=0, key_level[i]<=0, key_press[i]<=1 for one cycle.
  - HELD: sync=1 -> RELEASE_DEB, cnt=1.
  - RELEASE_DEB: mirror of PRESS_DEB. On acceptance -> IDLE, key_level[i]<=1, key_release[i]<=1 for one cycle.
- Latency: key_level changes exactly DEB_CNT+2 rising edges after the first edge that samples the new stable raw level (2 synchroniser stages + DEB_CNT qualification). The pulse is coincident with the key_level change.
- Any glitch shorter than DEB_CNT cycles, after synchronisation, produces no output change. A counter never exceeds DEB_CNT-1 and never wraps.
- Keys are fully independent. Simultaneous transitions on several keys yield simultaneous pulses.
- key_press and key_release are never both high for the same key in the same cycle.
- Pulse outputs are registered. There is no combinational path from key_in to any output.

Optional Feature:
Macro KEY_LONG_PRESS_EN.
- Defined: the key_long port and a per-key hold counter (26 bits) exist. The hold counter clears on entry to HELD and increments each cycle in HELD or RELEASE_DEB. When it reaches LONG_CNT-1, key_long[i] pulses for one cycle and the counter saturates, so there is one pulse per press. Leaving to IDLE clears it. A bounce that returns RELEASE_DEB -> HELD does not clear it.
- Not defined: no key_long port and no hold counters. All other behaviour is identical.

Test Plan:
- Reset check (DEB_CNT=20): hold rst=0 with key_in=2'b00 for 50 cycles -> key_level=2'b11, all pulses 0. Release rst -> key_level[0] goes 0 exactly 22 cycles after the first sampled edge.
- Clean press: key_in[0] 1->0 held for 40 cycles -> key_level[0]=0 at edge 22, key_press[0] high for exactly 1 cycle, key_release stays 0. Return to 1 -> key_release[0] pulse 22 edges later.
- Bounce: key_in[1] toggles every 5 cycles for 100 cycles and ends at 1 -> key_level[1] stays 1, no pulses.
- Near-miss: key_in[0] low for 19 cycles, then high -> no change. Low for 20 cycles -> accepted, single key_press[0].
- Simultaneous keys plus reset: both keys pressed on the same edge -> key_press=2'b11 in the same cycle. Assert rst at cnt=10 of a new press -> outputs back to reset values. After release, requalification takes a full 22 edges.
- With KEY_LONG_PRESS_EN (LONG_CNT=100): hold key 0 low for 300 cycles -> exactly one key_long[0] pulse, 100 cycles after key_press[0]. A 10-cycle release bounce in between does not reset the count.
